axi_mem_slave: RTL and testbench

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_mem_slave.sv | 194 +++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
// AXI-style memory slave: DEPTH sets of {64-bit tag word, 512-bit data line}.
// Define AXI_MEM_BACKDOOR_EN to add zero-latency write_8byte/write_64byte backdoor tasks.
module axi_mem_slave #(
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10,
  parameter int RD_LAT = 2,
  parameter int ID_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ID_W-1:0]   arid_i,
  input  logic [63:0]       araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [ID_W-1:0]   rid_o,
  output logic [575:0]      rdata_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  input  logic [ID_W-1:0]   awid_i,
  input  logic [63:0]       awaddr_i,
  input  logic              awvalid_i,
  output logic              awready_o,
  input  logic [ID_W-1:0]   wid_i,
  input  logic [511:0]      wdata_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  output logic [ID_W-1:0]   bid_o,
  output logic              bvalid_o,
  input  logic              bready_i
);

  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  logic [63:0]  tag_mem  [DEPTH];
  logic [511:0] data_mem [DEPTH];

  rd_state_t        state_q, state_d;
  logic [CNT_W-1:0] lat_cnt;
  logic             ar_fire;
  logic [IDX_W-1:0] ar_idx;

  logic             aw_held, w_held;
  logic [ID_W-1:0]  aw_id_q;
  logic [IDX_W-1:0] aw_idx_q;
  logic             aw_tag_q;
  logic [511:0]     w_data_q;
  logic             aw_fire, w_fire, commit;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_tag;
  logic [511:0]     wr_data;
  logic [ID_W-1:0]  wr_id;

  // Address bits outside the set index (and bit 63 for reads) and the W-channel ID carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{wid_i, araddr_i, awaddr_i};

  assign ar_fire = arvalid_i & arready_o;
  assign ar_idx  = araddr_i[6 +: IDX_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    arready_o = 1'b0;
    rvalid_o  = 1'b0;
    case (state_q)
      R_IDLE: begin
        arready_o = 1'b1;
        if (arvalid_i) begin
          state_d = (RD_LAT == 1) ? R_RESP : R_WAIT;
        end
      end
      R_WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          state_d = R_RESP;
        end
      end
      R_RESP: begin
        rvalid_o = 1'b1;
        if (rready_i) begin
          state_d = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Entry is snapshotted at the AR handshake, so a same-edge write is not visible to this read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
      rid_o   <= '0;
      rdata_o <= '0;
    end else begin
      if (ar_fire) begin
        lat_cnt <= '0;
        rid_o   <= arid_i;
        rdata_o <= {tag_mem[ar_idx], data_mem[ar_idx]};
      end else if (state_q == R_WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
    end
  end

  assign awready_o = !aw_held & !bvalid_o;
  assign wready_o  = !w_held & !bvalid_o;
  assign aw_fire   = awvalid_i & awready_o;
  assign w_fire    = wvalid_i & wready_o;
  assign commit    = (aw_held | aw_fire) & (w_held | w_fire);

  always_comb begin
    wr_idx  = aw_held ? aw_idx_q : awaddr_i[6 +: IDX_W];
    wr_tag  = aw_held ? aw_tag_q : awaddr_i[63];
    wr_id   = aw_held ? aw_id_q  : awid_i;
    wr_data = w_held  ? w_data_q : wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_id_q  <= '0;
      aw_idx_q <= '0;
      aw_tag_q <= 1'b0;
      w_data_q <= '0;
      bvalid_o <= 1'b0;
      bid_o    <= '0;
    end else begin
      if (bvalid_o && bready_i) begin
        bvalid_o <= 1'b0;
      end
      if (commit) begin
        bvalid_o <= 1'b1;
        bid_o    <= wr_id;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end else begin
        if (aw_fire) begin
          aw_held  <= 1'b1;
          aw_id_q  <= awid_i;
          aw_idx_q <= awaddr_i[6 +: IDX_W];
          aw_tag_q <= awaddr_i[63];
        end
        if (w_fire) begin
          w_held   <= 1'b1;
          w_data_q <= wdata_i;
        end
      end
    end
  end

`ifdef AXI_MEM_BACKDOOR_EN
  always @(posedge clk or negedge rst_n) begin
`else
  always_ff @(posedge clk or negedge rst_n) begin
`endif
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= '0;
      end
    end else if (commit) begin
      if (wr_tag) begin
        tag_mem[wr_idx] <= wr_data[63:0];
      end else begin
        data_mem[wr_idx] <= wr_data;
      end
    end
  end

`ifdef AXI_MEM_BACKDOOR_EN
  task automatic write_8byte(input logic [IDX_W-1:0] index, input logic [63:0] value);
    tag_mem[index] = value;
  endtask

  task automatic write_64byte(input logic [IDX_W-1:0] index, input logic [511:0] value);
    data_mem[index] = value;
  endtask
`endif

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave (default build, backdoor disabled).
module tb_axi_mem_slave;

  localparam int RD_LAT = 2;
  localparam int ID_W   = 16;

  localparam logic [511:0] DATA_A = 512'hddddddddddddddddd;
  localparam logic [511:0] DATA_B = 512'h1111_2222_3333_4444;
  localparam logic [511:0] DATA_C = 512'h5555_6666;
  localparam logic [63:0]  TAG_A  = 64'hc0000003c0000000;

  logic            clk;
  logic            rst_n;
  logic [ID_W-1:0] arid_i;
  logic [63:0]     araddr_i;
  logic            arvalid_i;
  logic            arready_o;
  logic [ID_W-1:0] rid_o;
  logic [575:0]    rdata_o;
  logic            rvalid_o;
  logic            rready_i;
  logic [ID_W-1:0] awid_i;
  logic [63:0]     awaddr_i;
  logic            awvalid_i;
  logic            awready_o;
  logic [ID_W-1:0] wid_i;
  logic [511:0]    wdata_i;
  logic            wvalid_i;
  logic            wready_o;
  logic [ID_W-1:0] bid_o;
  logic            bvalid_o;
  logic            bready_i;

  int test_count = 0;
  int fail_count = 0;

  axi_mem_slave #(.DEPTH(1024), .IDX_W(10), .RD_LAT(RD_LAT), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arid_i    (arid_i),
    .araddr_i  (araddr_i),
    .arvalid_i (arvalid_i),
    .arready_o (arready_o),
    .rid_o     (rid_o),
    .rdata_o   (rdata_o),
    .rvalid_o  (rvalid_o),
    .rready_i  (rready_i),
    .awid_i    (awid_i),
    .awaddr_i  (awaddr_i),
    .awvalid_i (awvalid_i),
    .awready_o (awready_o),
    .wid_i     (wid_i),
    .wdata_i   (wdata_i),
    .wvalid_i  (wvalid_i),
    .wready_o  (wready_o),
    .bid_o     (bid_o),
    .bvalid_o  (bvalid_o),
    .bready_i  (bready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [575:0] actual, input logic [575:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One complete write: W may lead AW by w_lead cycles, B is held off for b_hold cycles.
  task automatic applyStimulus(input logic [ID_W-1:0] id, input logic [63:0] addr,
                               input logic [511:0] data, input int w_lead, input int b_hold);
    @(negedge clk);
    wvalid_i = 1'b1;
    wdata_i  = data;
    wid_i    = id;
    for (int i = 0; i < w_lead; i++) begin
      @(negedge clk);
      wvalid_i = 1'b0;
      checkOutput("w_wait_wready", 576'(wready_o), 576'(0));
      checkOutput("w_wait_bvalid", 576'(bvalid_o), 576'(0));
    end
    awvalid_i = 1'b1;
    awid_i    = id;
    awaddr_i  = addr;
    @(negedge clk);
    awvalid_i = 1'b0;
    wvalid_i  = 1'b0;
    checkOutput("b_valid", 576'(bvalid_o), 576'(1));
    checkOutput("b_id", 576'(bid_o), 576'(id));
    for (int i = 0; i < b_hold; i++) begin
      @(negedge clk);
      checkOutput("b_hold_bvalid", 576'(bvalid_o), 576'(1));
      checkOutput("b_hold_awready", 576'(awready_o), 576'(0));
      checkOutput("b_hold_wready", 576'(wready_o), 576'(0));
    end
    bready_i = 1'b1;
    @(negedge clk);
    bready_i = 1'b0;
    checkOutput("b_done_bvalid", 576'(bvalid_o), 576'(0));
    checkOutput("b_done_awready", 576'(awready_o), 576'(1));
    checkOutput("b_done_wready", 576'(wready_o), 576'(1));
  endtask

  task automatic readEntry(input logic [ID_W-1:0] id, input logic [63:0] addr,
                           input logic [575:0] expected, input int r_hold);
    int cycles;
    @(negedge clk);
    arvalid_i = 1'b1;
    arid_i    = id;
    araddr_i  = addr;
    rready_i  = 1'b0;
    @(negedge clk);
    arvalid_i = 1'b0;
    checkOutput("r_arready_busy", 576'(arready_o), 576'(0));
    cycles = 1;
    while (rvalid_o !== 1'b1 && cycles < 16) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("r_latency", 576'(cycles), 576'(RD_LAT));
    checkOutput("r_id", 576'(rid_o), 576'(id));
    checkOutput("r_data", rdata_o, expected);
    for (int i = 0; i < r_hold; i++) begin
      @(negedge clk);
      checkOutput("r_hold_rvalid", 576'(rvalid_o), 576'(1));
      checkOutput("r_hold_rdata", rdata_o, expected);
      checkOutput("r_hold_arready", 576'(arready_o), 576'(0));
    end
    rready_i = 1'b1;
    @(negedge clk);
    rready_i = 1'b0;
    checkOutput("r_done_rvalid", 576'(rvalid_o), 576'(0));
    checkOutput("r_done_arready", 576'(arready_o), 576'(1));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_rvalid"}, 576'(rvalid_o), 576'(0));
    checkOutput({tag, "_bvalid"}, 576'(bvalid_o), 576'(0));
    checkOutput({tag, "_arready"}, 576'(arready_o), 576'(1));
    checkOutput({tag, "_awready"}, 576'(awready_o), 576'(1));
    checkOutput({tag, "_wready"}, 576'(wready_o), 576'(1));
    checkOutput({tag, "_rid"}, 576'(rid_o), 576'(0));
    checkOutput({tag, "_bid"}, 576'(bid_o), 576'(0));
    checkOutput({tag, "_rdata"}, rdata_o, 576'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    arid_i    = '0;
    araddr_i  = '0;
    arvalid_i = 1'b0;
    rready_i  = 1'b0;
    awid_i    = '0;
    awaddr_i  = '0;
    awvalid_i = 1'b0;
    wid_i     = '0;
    wdata_i   = '0;
    wvalid_i  = 1'b0;
    bready_i  = 1'b0;

    repeat (3) @(negedge clk);
    checkIdle("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkIdle("post_reset");

    readEntry(16'h0005, 64'h0000_0000_0000_0140, 576'(0), 0);

    applyStimulus(16'h1234, 64'h0000_0000_0000_0040, DATA_A, 0, 0);
    readEntry(16'h000a, 64'h0000_0000_0000_0040, {64'h0, DATA_A}, 0);

    applyStimulus(16'h4321, 64'h8000_0000_0000_0040, {448'h0, TAG_A}, 0, 2);
    readEntry(16'h000b, 64'h0000_000f_0000_0040, {TAG_A, DATA_A}, 4);

    applyStimulus(16'h0777, 64'h0000_0000_0000_0080, DATA_B, 3, 0);
    readEntry(16'h000c, 64'h0000_0000_0000_0080, {64'h0, DATA_B}, 0);

    // AR and AW/W to the same set on one edge; the write then completes while the read waits.
    @(negedge clk);
    arvalid_i = 1'b1;
    arid_i    = 16'h00cc;
    araddr_i  = 64'h0000_0000_0000_0080;
    awvalid_i = 1'b1;
    awid_i    = 16'h0bbb;
    awaddr_i  = 64'h0000_0000_0000_0080;
    wvalid_i  = 1'b1;
    wdata_i   = DATA_C;
    @(negedge clk);
    arvalid_i = 1'b0;
    awvalid_i = 1'b0;
    wvalid_i  = 1'b0;
    checkOutput("same_edge_bvalid", 576'(bvalid_o), 576'(1));
    checkOutput("same_edge_bid", 576'(bid_o), 576'(16'h0bbb));
    checkOutput("same_edge_rvalid_early", 576'(rvalid_o), 576'(0));
    bready_i = 1'b1;
    @(negedge clk);
    bready_i = 1'b0;
    checkOutput("same_edge_rvalid", 576'(rvalid_o), 576'(1));
    checkOutput("same_edge_rdata_old", rdata_o, {64'h0, DATA_B});
    checkOutput("same_edge_bvalid_done", 576'(bvalid_o), 576'(0));
    rready_i = 1'b1;
    @(negedge clk);
    rready_i = 1'b0;
    readEntry(16'h00cd, 64'h0000_0000_0000_0080, {64'h0, DATA_C}, 0);

    // Reset with a read in flight and a lone W held.
    @(negedge clk);
    arvalid_i = 1'b1;
    arid_i    = 16'h00ee;
    araddr_i  = 64'h0000_0000_0000_0040;
    wvalid_i  = 1'b1;
    wdata_i   = DATA_B;
    @(negedge clk);
    arvalid_i = 1'b0;
    wvalid_i  = 1'b0;
    checkOutput("mid_wready_held", 576'(wready_o), 576'(0));
    rst_n = 1'b0;
    #1;
    checkIdle("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("after_reset_rvalid", 576'(rvalid_o), 576'(0));
      checkOutput("after_reset_bvalid", 576'(bvalid_o), 576'(0));
      checkOutput("after_reset_wready", 576'(wready_o), 576'(1));
    end
    readEntry(16'h00ef, 64'h0000_0000_0000_0040, 576'(0), 0);
    readEntry(16'h00f0, 64'h0000_0000_0000_0080, 576'(0), 0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
